// File: rtl/sensor_cfg_seq.sv
// sensor_cfg_seq: walks one of MODES sensor register tables stored in an
// external synchronous ROM and turns each entry into a register write request
// for the camera control-bus master (I2C/SCCB). Besides plain writes, a table
// can hold delay entries (DELAY_ADDR, wait data*DELAY_UNIT cycles) and ends
// at an END_ADDR sentinel. NACKed writes are re-issued up to RETRIES times
// before the run aborts with a sticky error.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   start_i, mode_i     one-cycle start pulse and table select (idle only)
//   rom_rd_o/addr_o     ROM read strobe and word address
//   rom_data_i          ROM word {reg_addr, reg_data}, valid 1 cycle after rom_rd_o
//   wr_valid_o/ready_i  write request handshake towards the bus master
//   wr_addr_o/data_o    register address / data of the pending write
//   wr_done_i/nack_i    bus transaction finished / finished with NACK
//   busy_o              a table is being walked
//   done_o              one-cycle pulse: table finished cleanly
//   err_o               sticky error, cleared by the next accepted start
//   ops_cnt_o           entries consumed (writes + delays) in current/last run
//   dbg_state           current FSM state encoding, for observation
//
// Write handshake: wr_valid_o rises with wr_addr_o/wr_data_o already stable
// and holds them unchanged until a rising clock edge sees wr_valid_o and
// wr_ready_i both high; that edge is the transfer and wr_valid_o is low in
// the following cycle. Valid never depends combinationally on ready.

module sensor_cfg_seq #(
   parameter int                    MODES      = 4,
   parameter int                    MAX_OPS    = 256,
   parameter int                    REG_ADDR_W = 16,
   parameter int                    REG_DATA_W = 8,
   parameter logic [REG_ADDR_W-1:0] DELAY_ADDR = 16'hFFFF,
   parameter logic [REG_ADDR_W-1:0] END_ADDR   = 16'hFFFE,
   parameter int                    DELAY_UNIT = 1000,
   parameter int                    RETRIES    = 2,
   parameter int                    ROM_AW     = $clog2(MODES*MAX_OPS)
) (
   input  logic                               clk_i,
   input  logic                               rst_n_i,
   input  logic                               start_i,
   input  logic [$clog2(MODES)-1:0]           mode_i,
   output logic                               rom_rd_o,
   output logic [ROM_AW-1:0]                  rom_addr_o,
   input  logic [REG_ADDR_W+REG_DATA_W-1:0]   rom_data_i,
   output logic                               wr_valid_o,
   input  logic                               wr_ready_i,
   output logic [REG_ADDR_W-1:0]              wr_addr_o,
   output logic [REG_DATA_W-1:0]              wr_data_o,
   input  logic                               wr_done_i,
   input  logic                               wr_nack_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               err_o,
   output logic [$clog2(MAX_OPS+1)-1:0]       ops_cnt_o,
   output logic [2:0]                         dbg_state
);

   localparam int MW  = $clog2(MODES);
   localparam int CW  = $clog2(MAX_OPS+1);
   // Delay counter wide enough for the full data*DELAY_UNIT product.
   localparam int DLW = REG_DATA_W + $clog2(DELAY_UNIT+1);
   localparam int RTW = (RETRIES > 0) ? $clog2(RETRIES+1) : 1;
   localparam int RDW = REG_ADDR_W + REG_DATA_W;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      DECODE   = 3'd2,
      ISSUE    = 3'd3,
      WAIT_ACK = 3'd4,
      DELAY    = 3'd5,
      DONE     = 3'd6,
      ERROR    = 3'd7
   } state_t;

   state_t          state;
   logic [MW-1:0]   mode;
   logic [CW-1:0]   idx;
   logic [RTW-1:0]  retry;
   logic [DLW-1:0]  delay_cnt;

   logic [REG_ADDR_W-1:0] ent_addr;
   logic [REG_DATA_W-1:0] ent_data;
   logic [CW-1:0]         idx_nxt;
   logic                  nxt_in_table;
   logic [ROM_AW-1:0]     nxt_addr;
   logic [ROM_AW-1:0]     start_addr;
   logic                  mode_ok;

   assign ent_addr = rom_data_i[RDW-1 -: REG_ADDR_W];
   assign ent_data = rom_data_i[REG_DATA_W-1:0];

   // The read strobe is raised on the edge that enters FETCH, so the ROM word
   // is present during DECODE. Hence the next slot index and its address are
   // computed ahead of time; slot MAX_OPS is never read.
   assign idx_nxt      = idx + CW'(1);
   assign nxt_in_table = (idx_nxt != CW'(MAX_OPS));
   assign nxt_addr     = ROM_AW'(mode) * ROM_AW'(MAX_OPS) + ROM_AW'(idx_nxt);
   assign start_addr   = ROM_AW'(mode_i) * ROM_AW'(MAX_OPS);
   assign mode_ok      = (int'(mode_i) < MODES);

   assign dbg_state = state;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         mode       <= '0;
         idx        <= '0;
         retry      <= '0;
         delay_cnt  <= '0;
         rom_rd_o   <= 1'b0;
         rom_addr_o <= '0;
         wr_valid_o <= 1'b0;
         wr_addr_o  <= '0;
         wr_data_o  <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         ops_cnt_o  <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  mode      <= mode_i;
                  idx       <= '0;
                  retry     <= '0;
                  ops_cnt_o <= '0;
                  if (mode_ok) begin
                     err_o      <= 1'b0;
                     busy_o     <= 1'b1;
                     rom_rd_o   <= 1'b1;
                     rom_addr_o <= start_addr;
                     state      <= FETCH;
                  end else begin
                     // Unknown mode: abort without touching the ROM.
                     err_o <= 1'b1;
                     state <= ERROR;
                  end
               end
            end

            FETCH: begin
               rom_rd_o <= 1'b0;
               if (idx == CW'(MAX_OPS)) begin
                  // Ran off the end of the table without a sentinel.
                  err_o  <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= ERROR;
               end else begin
                  state <= DECODE;
               end
            end

            DECODE: begin
               if (ent_addr == END_ADDR) begin
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= DONE;
               end else if (ent_addr == DELAY_ADDR) begin
                  delay_cnt <= DLW'(ent_data) * DLW'(DELAY_UNIT);
                  state     <= DELAY;
               end else begin
                  wr_addr_o  <= ent_addr;
                  wr_data_o  <= ent_data;
                  wr_valid_o <= 1'b1;
                  state      <= ISSUE;
               end
            end

            ISSUE: begin
               if (wr_ready_i) begin
                  wr_valid_o <= 1'b0;
                  state      <= WAIT_ACK;
               end
            end

            WAIT_ACK: begin
               if (wr_done_i) begin
                  if (!wr_nack_i) begin
                     retry     <= '0;
                     idx       <= idx_nxt;
                     ops_cnt_o <= ops_cnt_o + CW'(1);
                     rom_rd_o  <= nxt_in_table;
                     if (nxt_in_table) rom_addr_o <= nxt_addr;
                     state     <= FETCH;
                  end else if (retry < RTW'(RETRIES)) begin
                     // Re-issue the same entry; addr/data are still held.
                     retry      <= retry + RTW'(1);
                     wr_valid_o <= 1'b1;
                     state      <= ISSUE;
                  end else begin
                     err_o  <= 1'b1;
                     busy_o <= 1'b0;
                     state  <= ERROR;
                  end
               end
            end

            DELAY: begin
               // Leaves after exactly data*DELAY_UNIT cycles here (one cycle
               // when the product is zero).
               if (delay_cnt <= DLW'(1)) begin
                  idx       <= idx_nxt;
                  ops_cnt_o <= ops_cnt_o + CW'(1);
                  rom_rd_o  <= nxt_in_table;
                  if (nxt_in_table) rom_addr_o <= nxt_addr;
                  state     <= FETCH;
               end else begin
                  delay_cnt <= delay_cnt - DLW'(1);
               end
            end

            DONE:    state <= IDLE;
            ERROR:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_cfg_seq.sv
// Directed testbench for sensor_cfg_seq with MODES=3, MAX_OPS=8,
// DELAY_UNIT=4, RETRIES=2. A synchronous ROM model and a bus-master responder
// (ACK/NACK 5 cycles after each accepted write) surround the design.

module tb_sensor_cfg_seq;

   localparam int ACK_DLY = 5;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_DELAY = 3'd5;
   localparam logic [2:0] S_ERROR = 3'd7;

   logic        clk_i, rst_n_i, start_i;
   logic [1:0]  mode_i;
   logic        rom_rd_o;
   logic [4:0]  rom_addr_o;
   logic [23:0] rom_data_i;
   logic        wr_valid_o, wr_ready_i;
   logic [15:0] wr_addr_o;
   logic [7:0]  wr_data_o;
   logic        wr_done_i, wr_nack_i;
   logic        busy_o, done_o, err_o;
   logic [3:0]  ops_cnt_o;
   logic [2:0]  dbg_state;

   sensor_cfg_seq #(
      .MODES(3), .MAX_OPS(8), .REG_ADDR_W(16), .REG_DATA_W(8),
      .DELAY_ADDR(16'hFFFF), .END_ADDR(16'hFFFE),
      .DELAY_UNIT(4), .RETRIES(2)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .mode_i(mode_i),
      .rom_rd_o(rom_rd_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
      .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
      .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .wr_done_i(wr_done_i), .wr_nack_i(wr_nack_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .ops_cnt_o(ops_cnt_o), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // ---------------- ROM model ----------------
   logic [23:0] rom [0:31];
   logic [23:0] rom_q;
   assign rom_data_i = rom_q;
   always @(posedge clk_i) if (rom_rd_o) rom_q <= rom[rom_addr_o];

   // ---------------- bus master responder ----------------
   int hs_seen   = 0;
   int nack_from = 0;
   int nack_to   = 0;
   int rst_gen   = 0;

   initial begin
      int  gen;
      logic nk;
      wr_done_i = 1'b0;
      wr_nack_i = 1'b0;
      @(negedge clk_i);
      forever begin
        #1;
        if (rst_n_i && wr_valid_o && wr_ready_i) begin
           gen = rst_gen;
           nk  = (hs_seen >= nack_from) && (hs_seen < nack_to);
           hs_seen++;
           repeat (ACK_DLY) @(negedge clk_i);
           if (gen == rst_gen) begin
              wr_done_i = 1'b1;
              wr_nack_i = nk;
           end
           @(negedge clk_i);
           wr_done_i = 1'b0;
           wr_nack_i = 1'b0;
        end else begin
           @(negedge clk_i);
        end
      end
   end

   // ---------------- scoreboard / monitors ----------------
   logic [23:0] exp_q[$];
   logic [23:0] act_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int done_cnt, rd_cnt, delay_cyc, valid_in_delay;
   logic [4:0] max_rd, first_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic clear_mon();
      act_q.delete();
      exp_q.delete();
      done_cnt = 0; rd_cnt = 0; delay_cyc = 0; valid_in_delay = 0;
      max_rd = '0; first_rd = '0;
   endtask

   // Sample this cycle's values (after the bench has driven its inputs),
   // then advance to the next falling edge.
   task automatic tick();
      if (rst_n_i) begin
         if (wr_valid_o && wr_ready_i) act_q.push_back({wr_addr_o, wr_data_o});
         if (done_o) done_cnt++;
         if (rom_rd_o) begin
            rd_cnt++;
            if (rd_cnt == 1) first_rd = rom_addr_o;
            if (rom_addr_o > max_rd) max_rd = rom_addr_o;
         end
         if (dbg_state == S_DELAY) begin
            delay_cyc++;
            if (wr_valid_o) valid_in_delay++;
         end
      end
      @(negedge clk_i);
   endtask

   task automatic start_run(input logic [1:0] m);
      start_i = 1'b1;
      mode_i  = m;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int k = 0;
      while (!(done_o || err_o) && k < 400) begin tick(); k++; end
      chk({tag, "_end_reached"}, 32'(k < 400), 32'd1);
   endtask

   task automatic wait_state(input logic [2:0] s, input string tag);
      int k = 0;
      while (dbg_state !== s && k < 300) begin tick(); k++; end
      chk({tag, "_state_reached"}, 32'(k < 300), 32'd1);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_wr_count"}, 32'(act_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         chk($sformatf("%s_wr%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [15:0] a0;
      logic [7:0]  d0;
      int unstable;
      int k;

      for (int i = 0; i < 32; i++) rom[i] = 24'h0;
      // mode 0: three writes then END
      rom[0] = 24'h03425f; rom[1] = 24'h0343c4; rom[2] = 24'h010001; rom[3] = 24'hFFFE00;
      // mode 1: write, delay 3 units, write, END
      rom[8] = 24'h300011; rom[9] = 24'hFFFF03; rom[10] = 24'h300122; rom[11] = 24'hFFFE00;
      // mode 2: eight writes, no sentinel
      for (int i = 0; i < 8; i++) rom[16+i] = {16'h4000 + 16'(i), 8'h10 + 8'(i)};

      rst_n_i = 1'b0; start_i = 1'b0; mode_i = 2'd0; wr_ready_i = 1'b1;
      clear_mon();
      repeat (3) @(negedge clk_i);
      rst_n_i = 1'b1;
      tick();

      // Reset values
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_wr_valid", wr_valid_o, 0);
      chk("rst_rom_rd", rom_rd_o, 0);
      chk("rst_ops", ops_cnt_o, 0);
      chk("rst_state", dbg_state, S_IDLE);

      // Mode 0, always ready, ACK; start during DONE cycle must be ignored
      clear_mon();
      exp_q = '{24'h03425f, 24'h0343c4, 24'h010001};
      start_run(2'd0);
      wait_end("m0");
      start_i = 1'b1; mode_i = 2'd1;
      tick();
      start_i = 1'b0;
      drain(3);
      check_writes("m0");
      chk("m0_done_cnt", done_cnt, 1);
      chk("m0_ops", ops_cnt_o, 3);
      chk("m0_err", err_o, 0);
      chk("m0_rom_reads", rd_cnt, 4);
      chk("m0_start_on_done_busy", busy_o, 0);
      chk("m0_start_on_done_state", dbg_state, S_IDLE);

      // Ready held low for 10 cycles during ISSUE
      clear_mon();
      exp_q = '{24'h03425f, 24'h0343c4, 24'h010001};
      wr_ready_i = 1'b0;
      start_run(2'd0);
      k = 0;
      while (!wr_valid_o && k < 50) begin tick(); k++; end
      chk("stall_valid_seen", 32'(k < 50), 1);
      a0 = wr_addr_o; d0 = wr_data_o;
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (wr_valid_o !== 1'b1 || wr_addr_o !== a0 || wr_data_o !== d0) unstable++;
      end
      chk("stall_stable", unstable, 0);
      chk("stall_no_hs", 32'(act_q.size()), 0);
      wr_ready_i = 1'b1;
      wait_end("stall");
      drain(3);
      check_writes("stall");
      chk("stall_done_cnt", done_cnt, 1);

      // NACK twice then ACK: same entry issued three times
      clear_mon();
      exp_q = '{24'h03425f, 24'h03425f, 24'h03425f, 24'h0343c4, 24'h010001};
      nack_from = hs_seen; nack_to = hs_seen + 2;
      start_run(2'd0);
      wait_end("retry_ok");
      drain(3);
      check_writes("retry_ok");
      chk("retry_ok_done_cnt", done_cnt, 1);
      chk("retry_ok_err", err_o, 0);
      chk("retry_ok_ops", ops_cnt_o, 3);

      // NACK three times: error, no done
      clear_mon();
      exp_q = '{24'h03425f, 24'h03425f, 24'h03425f};
      nack_from = hs_seen; nack_to = hs_seen + 3;
      start_run(2'd0);
      wait_end("retry_fail");
      drain(3);
      check_writes("retry_fail");
      chk("retry_fail_err", err_o, 1);
      chk("retry_fail_done_cnt", done_cnt, 0);
      chk("retry_fail_busy", busy_o, 0);
      chk("retry_fail_ops", ops_cnt_o, 0);

      // Delay entry 3 * 4 = 12 cycles; err cleared by the accepted start
      clear_mon();
      exp_q = '{24'h300011, 24'h300122};
      start_run(2'd1);
      chk("delay_err_cleared", err_o, 0);
      chk("delay_busy", busy_o, 1);
      wait_end("delay");
      drain(3);
      check_writes("delay");
      chk("delay_cycles", delay_cyc, 12);
      chk("delay_valid_inside", valid_in_delay, 0);
      chk("delay_ops", ops_cnt_o, 3);
      chk("delay_done_cnt", done_cnt, 1);

      // No sentinel in mode 2: error after 8 writes, reads stay in table
      clear_mon();
      for (int i = 0; i < 8; i++) exp_q.push_back({16'h4000 + 16'(i), 8'h10 + 8'(i)});
      start_run(2'd2);
      wait_end("nosent");
      drain(3);
      check_writes("nosent");
      chk("nosent_err", err_o, 1);
      chk("nosent_done_cnt", done_cnt, 0);
      chk("nosent_ops", ops_cnt_o, 8);
      chk("nosent_reads", rd_cnt, 8);
      chk("nosent_max_addr", max_rd, 23);

      // mode_i == MODES: straight to ERROR, no ROM reads
      clear_mon();
      start_run(2'd3);
      chk("badmode_state", dbg_state, S_ERROR);
      chk("badmode_err", err_o, 1);
      chk("badmode_busy", busy_o, 0);
      drain(3);
      chk("badmode_idle", dbg_state, S_IDLE);
      chk("badmode_reads", rd_cnt, 0);

      // Reset during WAIT_ACK of the second write
      clear_mon();
      start_run(2'd0);
      k = 0;
      while (!(dbg_state == S_WAIT && ops_cnt_o == 4'd1) && k < 200) begin tick(); k++; end
      chk("rst_wait_reached", 32'(k < 200), 1);
      chk("pre_rst_busy", busy_o, 1);
      #2 rst_n_i = 1'b0;
      rst_gen++;
      #1;
      chk("async_rst_busy", busy_o, 0);
      chk("async_rst_ops", ops_cnt_o, 0);
      chk("async_rst_state", dbg_state, S_IDLE);
      tick();
      rst_n_i = 1'b1;
      tick();

      // Reset while a write is held in ISSUE: valid drops immediately
      wr_ready_i = 1'b0;
      start_run(2'd0);
      wait_state(S_ISSUE, "rst_issue");
      chk("pre_rst_valid", wr_valid_o, 1);
      #2 rst_n_i = 1'b0;
      rst_gen++;
      #1;
      chk("async_rst_valid", wr_valid_o, 0);
      tick();
      rst_n_i = 1'b1;
      wr_ready_i = 1'b1;
      tick();

      // Restart with mode 1; a start pulse mid-run is ignored
      clear_mon();
      exp_q = '{24'h300011, 24'h300122};
      start_run(2'd1);
      wait_state(S_DELAY, "restart");
      start_i = 1'b1; mode_i = 2'd0;
      tick();
      start_i = 1'b0;
      wait_end("restart");
      drain(4);
      chk("restart_first_addr", first_rd, 8);
      check_writes("restart");
      chk("restart_done_cnt", done_cnt, 1);
      chk("restart_ops", ops_cnt_o, 3);
      chk("restart_busy_after", busy_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sensor_cfg_seq.md
Name: sensor_cfg_seq

Overview:
- Parametrised successor to the fixed single-mode sensor register tables (16-bit register address plus 8-bit data per entry).
- Walks one of MODES register tables held in an external synchronous ROM. Each entry becomes a write request to the camera control-bus master (I2C/SCCB).
- Also supports delay entries, end-of-table sentinels, per-write retry and error reporting.
- Sits between the sensor mode ROM and the I2C master, ahead of the CSI-2 receiver bring-up.

Parameters:
- MODES, 4, number of mode tables in the ROM.
- MAX_OPS, 256, entry slots per mode; table m occupies ROM words m*MAX_OPS .. m*MAX_OPS+MAX_OPS-1.
- REG_ADDR_W, 16, register address width.
- REG_DATA_W, 8, register data width.
- DELAY_ADDR, 16'hFFFF, entry address that means "wait data*DELAY_UNIT cycles".
- END_ADDR, 16'hFFFE, entry address that terminates the table.
- DELAY_UNIT, 1000, clock cycles per delay count.
- RETRIES, 2, re-issues of a NACKed write before error.
- ROM_AW, $clog2(MODES*MAX_OPS), ROM address width.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse: run table mode_i. Ignored unless idle.
- mode_i  in  $clog2(MODES)  mode select, sampled with start_i.
- rom_rd_o  out  1  ROM read strobe.
- rom_addr_o  out  ROM_AW  ROM word address.
- rom_data_i  in  REG_ADDR_W+REG_DATA_W  ROM word {addr,data}. Valid exactly 1 cycle after rom_rd_o.
- wr_valid_o  out  1  write request valid.
- wr_ready_i  in  1  master accepts the request.
- wr_addr_o  out  REG_ADDR_W  register address.
- wr_data_o  out  REG_DATA_W  register data.
- wr_done_i  in  1  one-cycle pulse: bus transaction finished.
- wr_nack_i  in  1  qualifies wr_done_i; 1 means the write failed.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse: table completed without error.
- err_o  out  1  sticky error; cleared by the next accepted start_i.
- ops_cnt_o  out  $clog2(MAX_OPS+1)  entries consumed in the current/last run.

Behaviour:
- Reset values: every output 0; FSM in IDLE.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, DELAY, DONE, ERROR.
- IDLE: on start_i, latch mode, set idx=0, ops_cnt=0, err_o=0, retry=0; go to FETCH. busy_o=1 from the next cycle.
- FETCH:
  - If idx==MAX_OPS, the table has no sentinel: go to ERROR.
  - Otherwise drive rom_rd_o=1 and rom_addr_o=mode*MAX_OPS+idx for one cycle, then go to DECODE.
- DECODE: capture rom_data_i.
  - addr==END_ADDR: go to DONE. The sentinel is not counted.
  - addr==DELAY_ADDR: load delay counter with data*DELAY_UNIT (full-width product). data==0 means no wait. Go to DELAY.
  - Otherwise load wr_addr_o/wr_data_o and go to ISSUE.
- ISSUE:
  - Hold wr_valid_o=1 with stable addr/data until wr_valid_o&&wr_ready_i (AXI-style; valid never drops before acceptance).
  - Go to WAIT_ACK with wr_valid_o=0 the next cycle.
- WAIT_ACK: wait for wr_done_i.
  - nack=0: ops_cnt++, idx++, retry=0, go to FETCH.
  - nack=1 and retry<RETRIES: retry++, go to ISSUE with the same entry.
  - Otherwise go to ERROR.
- DELAY: count down to 0; on reaching 0, ops_cnt++, idx++, go to FETCH.
- DONE: done_o=1 for one cycle, busy_o=0, return to IDLE.
- ERROR: err_o=1 (sticky), busy_o=0, return to IDLE. done_o is not pulsed.
- Timing:
  - Per write, at least 4 cycles of overhead (FETCH, DECODE, ISSUE, WAIT_ACK) plus bus time.
  - Back-to-back entries issue no extra idle cycles beyond this.
- Boundary conditions:
  - start_i while busy_o=1 is ignored with no side effects.
  - start_i in the same cycle as done_o (FSM in DONE) is ignored.
  - A wr_done_i pulse outside WAIT_ACK is ignored.
  - mode_i >= MODES: enter ERROR next cycle with no ROM reads.
  - Reset asserted mid-operation: immediate return to reset values; wr_valid_o drops asynchronously.
  - ops_cnt_o holds its last value in IDLE.

Test Plan:
- Mode 0 table with 3 writes (0x0342=5f, 0x0343=c4, 0x0100=01) then END; always-ready master, ACK after 5 cycles -> three handshakes in order with exact addr/data; done_o pulses once; ops_cnt_o=3; err_o=0.
- wr_ready_i held low for 10 cycles during ISSUE -> wr_valid_o, wr_addr_o and wr_data_o remain stable; exactly one handshake occurs.
- One write NACKed twice, then ACKed, with RETRIES=2 -> 3 handshakes for the same entry; completes with done_o. NACKed 3 times -> err_o=1, no done_o, busy_o=0.
- Delay entry {FFFF,03} with DELAY_UNIT=4 -> 12 idle cycles with no wr_valid_o between the surrounding writes; ops_cnt_o includes the delay entry.
- Table with no END_ADDR across all MAX_OPS=8 slots -> err_o after 8 writes; rom_addr_o never exceeds mode*8+7. mode_i=MODES -> err_o with no rom_rd_o.
- Assert rst_n_i during WAIT_ACK, then restart with mode 1 -> outputs return to 0 immediately; first rom_addr_o = MAX_OPS; start_i issued mid-run is ignored.
